// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch opcode, state and width definitions for the core
package cpu_pkg;

  localparam int BR_OP_W = 3;

  typedef enum logic [BR_OP_W-1:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BNE  = 3'b011,
    BR_BGE  = 3'b100,
    BR_JMP  = 3'b101,
    BR_HALT = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition decode from ALU flags
module branch_cond
  import cpu_pkg::*;
(
  input  logic [BR_OP_W-1:0] br_op,
  input  logic               equal,
  input  logic               lessthan,
  output logic               taken,
  output logic               is_halt
);

  // Map opcode and flags to a taken decision; halt is reported separately, never as taken
  always_comb begin
    taken   = 1'b0;
    is_halt = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  taken = equal;
      BR_BLT:  taken = lessthan;
      BR_BNE:  taken = ~equal;
      BR_BGE:  taken = ~lessthan;
      BR_JMP:  taken = 1'b1;
      BR_HALT: is_halt = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - program counter, branch resolution and fetch flush control
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W         = 16,
  parameter int          TGT_W        = 8,
  parameter int          REL_BR       = 0,
  parameter int          FLUSH_CYCLES = 1,
  parameter int unsigned START_PC     = 0,
  parameter int          CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic [BR_OP_W-1:0] br_op,
  input  logic               equal,
  input  logic               lessthan,
  input  logic [TGT_W-1:0]   target,
  output logic [PC_W-1:0]    pc,
  output logic               branch,
  output logic               flush,
  output logic               halted,
  output logic [CNT_W-1:0]   taken_count
);

  if (TGT_W > PC_W) begin : g_tgt_chk
    $error("TGT_W must not exceed PC_W");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_flush_chk
    $error("FLUSH_CYCLES must be in 1..7");
  end

  state_e          state;
  logic [2:0]      fcnt;
  logic            taken;
  logic            is_halt;
  logic [PC_W-1:0] br_target;

  branch_cond u_cond (
    .br_op    (br_op),
    .equal    (equal),
    .lessthan (lessthan),
    .taken    (taken),
    .is_halt  (is_halt)
  );

  // Branch destination: absolute zero-extended target or pc-relative signed offset
  always_comb begin
    br_target = PC_W'(target);
    if (REL_BR != 0) begin
      br_target = pc + PC_W'($signed(target));
    end
  end

  // Control FSM; stall freezes everything except the one-cycle branch pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      branch      <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
      taken_count <= '0;
      fcnt        <= '0;
    end else if (stall) begin
      branch <= 1'b0;
    end else begin
      branch <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= PC_W'(START_PC);
            state <= RUN;
          end
        end
        RUN: begin
          if (is_halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (taken) begin
            pc     <= br_target;
            branch <= 1'b1;
            flush  <= 1'b1;
            fcnt   <= 3'(FLUSH_CYCLES - 1);
            state  <= FLUSH;
            if (taken_count != '1) begin
              taken_count <= taken_count + CNT_W'(1);
            end
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        FLUSH: begin
          // Wrong-path opcodes are ignored while the pipe drains
          pc <= pc + PC_W'(1);
          if (fcnt == 3'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        HALT: begin
          if (start) begin
            pc     <= PC_W'(START_PC);
            halted <= 1'b0;
            state  <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for two branch_pc_unit configurations
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, equal, lessthan;
  logic [2:0]  br_op;
  logic [7:0]  target;

  logic [15:0] pc0, pc1;
  logic        branch0, branch1, flush0, flush1, halted0, halted1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  // absolute targets, single flush cycle, wide counter
  branch_pc_unit #(
    .PC_W(16), .TGT_W(8), .REL_BR(0), .FLUSH_CYCLES(1), .START_PC(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .br_op(br_op),
    .equal(equal), .lessthan(lessthan), .target(target), .pc(pc0),
    .branch(branch0), .flush(flush0), .halted(halted0), .taken_count(cnt0)
  );

  // relative targets, three flush cycles, 2-bit saturating counter
  branch_pc_unit #(
    .PC_W(16), .TGT_W(8), .REL_BR(1), .FLUSH_CYCLES(3), .START_PC(16'h0010), .CNT_W(2)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .br_op(br_op),
    .equal(equal), .lessthan(lessthan), .target(target), .pc(pc1),
    .branch(branch1), .flush(flush1), .halted(halted1), .taken_count(cnt1)
  );

  typedef struct {
    int pc;
    bit br;
    bit fl;
    bit ht;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  // reference model: each unit is either waiting for start, running, halted,
  // or draining some number of remaining flush cycles
  int cfg_rel[2]   = '{0, 1};
  int cfg_fc[2]    = '{1, 3};
  int cfg_max[2]   = '{65535, 3};
  int cfg_start[2] = '{0, 16'h0010};

  bit m_wait[2];
  bit m_halt[2];
  int m_left[2];
  int m_pc[2];
  int m_cnt[2];
  bit m_br[2];
  bit m_fl[2];

  function automatic bit cond_taken(input logic [2:0] op, input bit e, input bit l);
    case (op)
      3'd1:    return e;
      3'd2:    return l;
      3'd3:    return !e;
      3'd4:    return !l;
      3'd5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input int i, input bit r, input bit st, input bit sl,
                            input logic [2:0] op, input bit e, input bit l,
                            input logic [7:0] t);
    int off;
    if (r) begin
      m_wait[i] = 1; m_halt[i] = 0; m_left[i] = 0;
      m_pc[i] = 0; m_cnt[i] = 0; m_br[i] = 0; m_fl[i] = 0;
    end else if (sl) begin
      m_br[i] = 0;
    end else begin
      m_br[i] = 0;
      if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
        m_pc[i] = (m_pc[i] + 1) % 65536;
        m_fl[i] = (m_left[i] > 0);
      end else if (m_wait[i] || m_halt[i]) begin
        if (st) begin
          m_pc[i] = cfg_start[i];
          m_wait[i] = 0;
          m_halt[i] = 0;
        end
      end else if (op == 3'd6) begin
        m_halt[i] = 1;
      end else if (cond_taken(op, e, l)) begin
        off = (t >= 128) ? int'(t) - 256 : int'(t);
        if (cfg_rel[i] != 0) m_pc[i] = (m_pc[i] + off + 65536) % 65536;
        else m_pc[i] = int'(t);
        m_br[i] = 1;
        m_fl[i] = 1;
        m_left[i] = cfg_fc[i];
        if (m_cnt[i] < cfg_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_pc[i] = (m_pc[i] + 1) % 65536;
      end
    end
  endtask

  task automatic step(input bit r, input bit st, input bit sl, input logic [2:0] op,
                      input bit e, input bit l, input logic [7:0] t);
    exp_t x;
    @(negedge clk);
    reset = r; start = st; stall = sl; br_op = op;
    equal = e; lessthan = l; target = t;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, st, sl, op, e, l, t);
      x.pc = m_pc[i]; x.br = m_br[i]; x.fl = m_fl[i]; x.ht = m_halt[i]; x.cnt = m_cnt[i];
      if (i == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: outputs are valid every cycle, so compare one expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("pc0", 32'(pc0), 32'(e.pc));
        chk("branch0", 32'(branch0), 32'(e.br));
        chk("flush0", 32'(flush0), 32'(e.fl));
        chk("halted0", 32'(halted0), 32'(e.ht));
        chk("count0", 32'(cnt0), 32'(e.cnt));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("pc1", 32'(pc1), 32'(e.pc));
        chk("branch1", 32'(branch1), 32'(e.br));
        chk("flush1", 32'(flush1), 32'(e.fl));
        chk("halted1", 32'(halted1), 32'(e.ht));
        chk("count1", 32'(cnt1), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1; start = 0; stall = 0; br_op = 0; equal = 0; lessthan = 0; target = 0;

    // reset, start, straight-line fetch
    step(1, 0, 0, 3'd0, 0, 0, 8'h00);
    step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    step(0, 1, 0, 3'd0, 0, 0, 8'h00);
    repeat (3) step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    // taken beq, then wrong-path jmp/halt during flush, with a stall in flush
    step(0, 0, 0, 3'd1, 1, 0, 8'h40);
    step(0, 0, 0, 3'd5, 0, 0, 8'h20);
    step(0, 0, 1, 3'd6, 0, 0, 8'h00);
    step(0, 0, 0, 3'd6, 0, 0, 8'h00);
    step(0, 0, 0, 3'd5, 0, 0, 8'h11);
    repeat (2) step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    // blt taken with negative offset, then not taken
    step(0, 0, 0, 3'd2, 0, 1, 8'hFC);
    repeat (3) step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    step(0, 0, 0, 3'd2, 0, 0, 8'hFC);
    // halt, hold, start ignored while stalled, then restart
    step(0, 0, 0, 3'd6, 0, 0, 8'h00);
    repeat (10) step(0, 0, 0, 3'd5, 0, 0, 8'h33);
    step(0, 1, 1, 3'd0, 0, 0, 8'h00);
    step(0, 1, 0, 3'd0, 0, 0, 8'h00);
    // five taken branches to saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 3'd3, 0, 0, 8'h08);
      repeat (3) step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    end
    // reset in the middle of a flush
    step(0, 0, 0, 3'd5, 0, 0, 8'h80);
    step(0, 0, 0, 3'd0, 0, 0, 8'h00);
    step(1, 0, 0, 3'd0, 0, 0, 8'h00);
    step(0, 0, 0, 3'd0, 0, 0, 8'h00);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
